// File: rtl/uart_rx_core.sv
// Parametrised UART receiver: 2-flop synchroniser, mid-bit sampling, optional parity,
// 1 or 2 stop bits, and a valid/ready output port with an overrun pulse.
module uart_rx_core #(
    parameter int unsigned DATA_BITS    = 8,
    parameter int unsigned CLKS_PER_BIT = 868,
    parameter int unsigned PARITY       = 0,
    parameter int unsigned STOP_BITS    = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic                 parity_err,
    output logic                 frame_err,
    output logic                 overrun,
    output logic                 busy
);

    localparam int unsigned TW = $clog2(CLKS_PER_BIT);
    localparam int unsigned BW = $clog2(DATA_BITS);
    localparam logic [TW-1:0] MID_CNT  = TW'((CLKS_PER_BIT - 1) / 2);
    localparam logic [TW-1:0] LAST_CNT = TW'(CLKS_PER_BIT - 1);
    localparam logic [BW-1:0] LAST_BIT = BW'(DATA_BITS - 1);
    localparam logic          LAST_STP = 1'(STOP_BITS - 1);
    localparam logic          ODD_PAR  = (PARITY == 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP,
        S_DONE
    } state_t;

    state_t                 r_state;
    logic                   r_rx_s1;
    logic                   r_rx_s2;
    logic                   r_rx_prev;
    logic [TW-1:0]          r_timer;
    logic [BW-1:0]          r_bit;
    logic                   r_stop;
    logic [DATA_BITS-1:0]   r_shift;
    logic                   r_perr;
    logic                   r_ferr;

    logic w_rxs;
    logic w_fall;
    logic w_mid;
    logic w_bit_tick;
    logic w_accept;
    logic w_par_bad;

    assign w_rxs      = r_rx_s2;
    assign w_fall     = r_rx_prev & ~w_rxs;
    assign w_mid      = (r_timer == MID_CNT);
    assign w_bit_tick = (r_timer == LAST_CNT);
    assign w_accept   = rx_valid & rx_ready;
    assign w_par_bad  = ((^r_shift) ^ w_rxs) != ODD_PAR;
    assign busy       = (r_state != S_IDLE);

    // Receive FSM; a start edge seen in DONE goes straight to START so back-to-back frames survive
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_rx_s1    <= 1'b1;
            r_rx_s2    <= 1'b1;
            r_rx_prev  <= 1'b1;
            r_timer    <= '0;
            r_bit      <= '0;
            r_stop     <= 1'b0;
            r_shift    <= '0;
            r_perr     <= 1'b0;
            r_ferr     <= 1'b0;
            rx_data    <= '0;
            rx_valid   <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            r_rx_s1   <= rx;
            r_rx_s2   <= r_rx_s1;
            r_rx_prev <= w_rxs;
            overrun   <= 1'b0;
            r_timer   <= r_timer + TW'(1);
            if (w_accept) begin
                rx_valid <= 1'b0;
            end
            case (r_state)
                S_IDLE: begin
                    r_timer <= '0;
                    if (w_fall) begin
                        r_state <= S_START;
                    end
                end
                S_START: begin
                    if (w_mid) begin
                        r_timer <= '0;
                        if (!w_rxs) begin
                            r_state <= S_DATA;
                            r_bit   <= '0;
                            r_perr  <= 1'b0;
                            r_ferr  <= 1'b0;
                        end else begin
                            r_state <= S_IDLE;
                        end
                    end
                end
                S_DATA: begin
                    if (w_bit_tick) begin
                        r_timer <= '0;
                        r_shift <= {w_rxs, r_shift[DATA_BITS-1:1]};
                        r_bit   <= r_bit + BW'(1);
                        if (r_bit == LAST_BIT) begin
                            r_stop  <= 1'b0;
                            r_state <= (PARITY != 0) ? S_PARITY : S_STOP;
                        end
                    end
                end
                S_PARITY: begin
                    if (w_bit_tick) begin
                        r_timer <= '0;
                        r_perr  <= w_par_bad;
                        r_state <= S_STOP;
                    end
                end
                S_STOP: begin
                    if (w_bit_tick) begin
                        r_timer <= '0;
                        if (!w_rxs) begin
                            r_ferr <= 1'b1;
                        end
                        if (r_stop == LAST_STP) begin
                            r_state <= S_DONE;
                        end else begin
                            r_stop <= r_stop + 1'b1;
                        end
                    end
                end
                S_DONE: begin
                    r_timer <= '0;
                    if (!rx_valid || w_accept) begin
                        rx_data    <= r_shift;
                        parity_err <= r_perr;
                        frame_err  <= r_ferr;
                        rx_valid   <= 1'b1;
                    end else begin
                        overrun <= 1'b1;
                    end
                    r_state <= w_fall ? S_START : S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
